// File: rtl/dds_voice_bank.sv
// Time-multiplexed DDS voice bank: one shared phase/wave datapath,
// one voice per clock, averaged into a single sample per frame.
module dds_voice_bank #(
   parameter  int NUM_VOICES = 4,
   parameter  int TUNE_W     = 16,
   parameter  int PHASE_W    = 16,
   parameter  int WAVE_W     = 12,
   parameter  int DIV_W      = 8,
   localparam int VA_W       = $clog2(NUM_VOICES),
   localparam int ADDR_W     = VA_W + 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [DIV_W-1:0]  div_sel,
   output logic [WAVE_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, VOICE, OUT} state_t;

   state_t state, state_nx;

   logic [PHASE_W-1:0] phase  [NUM_VOICES];
   logic [TUNE_W-1:0]  tune   [NUM_VOICES];
   logic [7:0]         shadow [NUM_VOICES];
   logic [4:0]         ctrl   [NUM_VOICES];
   logic [7:0]         pw     [NUM_VOICES];
   logic [NUM_VOICES-1:0] wrap;

   logic [DIV_W-1:0]       cnt;
   logic                   tick;
   logic [VA_W-1:0]        v, v_prev;
   logic                   last;
   logic [WAVE_W+VA_W-1:0] mix, mix_sum;
   logic [15:0]            lfsr, lfsr_nx;

   logic [VA_W-1:0]    wr_v;
   logic [1:0]         wr_r;
   logic [15:0]        tune_full;

   logic               en_v, sync_v;
   logic [2:0]         wave_v;
   logic [PHASE_W:0]   sum;
   logic [PHASE_W-1:0] ph_new;
   logic [WAVE_W-1:0]  p, wv, voice_out, noise;

   assign wr_v      = wr_addr[ADDR_W-1:2];
   assign wr_r      = wr_addr[1:0];
   assign tune_full = {wr_data, shadow[wr_v]};

   // tuning commits in one edge, so a slot never sees half a word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            shadow[i] <= '0;
            tune[i]   <= '0;
            ctrl[i]   <= '0;
            pw[i]     <= '0;
         end
      end else if (wr_en) begin
         unique case (wr_r)
            2'd0: shadow[wr_v] <= wr_data;
            2'd1: tune[wr_v]   <= tune_full[TUNE_W-1:0];
            2'd2: ctrl[wr_v]   <= wr_data[4:0];
            2'd3: pw[wr_v]     <= wr_data;
         endcase
      end
   end

   assign tick = ena && (cnt == div_sel);

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (ena)
         cnt <= tick ? '0 : cnt + DIV_W'(1);
   end

   assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   generate
      if (WAVE_W <= 16) begin : g_noise_narrow
         assign noise = lfsr[15 -: WAVE_W];
      end else begin : g_noise_wide
         assign noise = {lfsr, {(WAVE_W-16){1'b0}}};
      end
   endgenerate

   assign en_v   = ctrl[v][0];
   assign sync_v = ctrl[v][1];
   assign wave_v = ctrl[v][4:2];
   assign v_prev = v - VA_W'(1);
   assign last   = (v == VA_W'(NUM_VOICES-1));

   // voice 0 reads voice N-1's flag left over from the previous frame
   assign sum    = {1'b0, phase[v]} + (PHASE_W+1)'(tune[v]);
   assign ph_new = (sync_v && wrap[v_prev]) ? '0 : sum[PHASE_W-1:0];
   assign p      = ph_new[PHASE_W-1 -: WAVE_W];

   always_comb begin
      wv = '0;
      unique case (wave_v)
         3'd0:    wv = p;
         3'd1:    wv = ~p;
         3'd2:    wv = {p[WAVE_W-2:0], 1'b0} ^ {WAVE_W{p[WAVE_W-1]}};
         3'd3:    wv = (p[WAVE_W-1 -: 8] < pw[v]) ? '1 : '0;
         3'd4:    wv = noise;
         default: wv = '0;
      endcase
   end

   assign voice_out = en_v ? wv : '0;
   assign mix_sum   = mix + (WAVE_W+VA_W)'(voice_out);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (tick) state_nx = VOICE;
         VOICE:   if (last) state_nx = OUT;
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // the sample registers on the last slot so it is visible during OUT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         v            <= '0;
         mix          <= '0;
         wrap         <= '0;
         lfsr         <= 16'hACE1;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++)
            phase[i] <= '0;
      end else begin
         state        <= state_nx;
         sample_valid <= 1'b0;
         if (tick && state != IDLE)
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (tick) begin
                  v   <= '0;
                  mix <= '0;
               end
            end
            VOICE: begin
               if (en_v)
                  phase[v] <= ph_new;
               wrap[v] <= en_v & sum[PHASE_W];
               mix     <= mix_sum;
               v       <= v + VA_W'(1);
               if (last) begin
                  sample_out   <= mix_sum[WAVE_W+VA_W-1:VA_W];
                  sample_valid <= 1'b1;
               end
            end
            OUT:     lfsr <= lfsr_nx;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_voice_bank.sv
// Directed bench for dds_voice_bank: saw, waves, pulse, sync,
// atomic tuning, overrun and mid-frame reset with fixed expectations.
module tb_dds_voice_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  div_sel = 8'd7;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        overrun;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dds_voice_bank dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .div_sel      (div_sel),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      ena   = 1'b0;
      wr_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", sample_out, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_ovr", overrun, 0);
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_valid && n < 64);
      if (!sample_valid)
         check("timeout", 0, 1);
   endtask

   task automatic frame(input string tag, input logic [11:0] exp);
      int n;
      wait_valid(n);
      check(tag, sample_out, exp);
   endtask

   task automatic saw_setup();
      wr(4'd0, 8'h00);
      wr(4'd1, 8'h10);
      wr(4'd2, 8'h01);
   endtask

   logic [11:0] sync_exp [8] = '{12'h004, 12'h008, 12'h00C, 12'h000,
                                 12'h004, 12'h008, 12'h00C, 12'h000};

   initial begin
      int n;
      int seen;

      // saw ramp, then inverse saw and triangle on the same voice
      hold_reset();
      saw_setup();
      ena = 1'b1;
      wait_valid(n);
      check("lat", n, 12);
      check("saw1", sample_out, 12'h040);
      for (int k = 2; k <= 17; k++) begin
         wait_valid(n);
         if (k < 5)
            check("period", n, 8);
         check("saw", sample_out, 12'((k % 16) * 64));
      end
      wr(4'd2, 8'h05);
      frame("isaw", 12'h37F);
      wr(4'd2, 8'h09);
      frame("tri", 12'h180);

      // pulse on voice 1, then PW=0
      hold_reset();
      wr(4'd4, 8'h00);
      wr(4'd5, 8'h08);
      wr(4'd7, 8'h80);
      wr(4'd6, 8'h0D);
      ena = 1'b1;
      for (int k = 1; k <= 32; k++)
         frame("pulse", (k < 16 || k == 32) ? 12'h3FF : 12'h000);
      wr(4'd7, 8'h00);
      for (int k = 0; k < 3; k++)
         frame("pw0", 12'h000);

      // hard sync: voice1 follows voice0's wrap, voice0 silenced
      hold_reset();
      wr(4'd0, 8'h00);
      wr(4'd1, 8'h40);
      wr(4'd2, 8'h15);
      wr(4'd4, 8'h00);
      wr(4'd5, 8'h01);
      wr(4'd6, 8'h03);
      ena = 1'b1;
      for (int k = 0; k < 8; k++)
         frame("sync", sync_exp[k]);

      // atomic tuning update
      hold_reset();
      saw_setup();
      ena = 1'b1;
      frame("at1", 12'h040);
      frame("at2", 12'h080);
      wr(4'd0, 8'h34);
      frame("at3", 12'h0C0);
      frame("at4", 12'h100);
      wr(4'd1, 8'h12);
      frame("at5", 12'h148);
      frame("at6", 12'h191);
      wr(4'd0, 8'h00);
      repeat (3) @(negedge clk);
      wr(4'd1, 8'h20);
      frame("at_slot", 12'h1DA);
      frame("at_next", 12'h25A);

      // overrun with a 4-cycle period
      hold_reset();
      div_sel = 8'd3;
      saw_setup();
      ena = 1'b1;
      repeat (2) @(negedge clk);
      check("ovr_pre", overrun, 0);
      wait_valid(n);
      check("ovr_lat", n, 6);
      check("ovr_s1", sample_out, 12'h040);
      check("ovr_set", overrun, 1);
      wait_valid(n);
      check("ovr_per", n, 8);
      check("ovr_s2", sample_out, 12'h080);
      ena  = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (sample_valid)
            seen++;
      end
      check("ena0_quiet", seen, 0);
      check("ovr_sticky", overrun, 1);

      // reset two cycles after a tick
      div_sel = 8'd7;
      ena     = 1'b1;
      wait_valid(n);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b0;
      seen  = 0;
      repeat (6) begin
         @(negedge clk);
         if (sample_valid)
            seen++;
      end
      check("mid_valid", seen, 0);
      check("mid_out", sample_out, 0);
      check("mid_ovr", overrun, 0);
      rst_n = 1'b1;
      saw_setup();
      ena = 1'b1;
      wait_valid(n);
      check("post_lat", n, 12);
      check("post_s1", sample_out, 12'h040);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
